// File: rtl/mux_scan_pkg.sv
// Shared definitions for the scanning N-channel multiplexer.
package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Upper bound on channel count supported by the one-hot helper.
    localparam int unsigned MAX_CHANNELS = 64;

    function automatic logic [MAX_CHANNELS-1:0] onehot(input int unsigned idx);
        onehot = MAX_CHANNELS'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_scan_n_tick.sv
// Dwell counter: tick marks the last cycle of a channel's dwell period.
module scan_tick_gen #(
    parameter int unsigned DWELL = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CNT_W-1:0] dwell;

    assign tick = (dwell == CNT_W'(DWELL - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            dwell <= '0;
        end else if (enable) begin
            dwell <= tick ? '0 : dwell + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_scan_n.sv
// N-channel registered multiplexer with manual select and timed auto-scan.
module mux_scan_n
    import mux_scan_pkg::*;
#(
    parameter  int unsigned WIDTH    = 4,
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned DWELL    = 1000,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      hold,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          ch_idx,
    output logic [CHANNELS-1:0]       ch_onehot,
    output logic                      wrap,
    output logic                      sel_err
);

    logic             tick;
    logic             scan_en;
    logic             dwell_clr;
    logic [SEL_W-1:0] idx_next;
    logic             wrap_next;
    logic             sel_err_next;

    // Counter runs only while scanning; manual mode keeps it parked at zero
    // so a later switch to scan gives the current channel a full dwell.
    assign scan_en   = (mode == MODE_SCAN) && !hold;
    assign dwell_clr = (mode == MODE_MANUAL) && !hold;

    scan_tick_gen #(
        .DWELL (DWELL)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (scan_en),
        .clear  (dwell_clr),
        .tick   (tick)
    );

    always_comb begin
        idx_next     = ch_idx;
        wrap_next    = 1'b0;
        sel_err_next = 1'b0;
        if (!hold) begin
            if (mode == MODE_MANUAL) begin
                if (32'(sel) < CHANNELS) begin
                    idx_next = sel;
                end else begin
                    sel_err_next = 1'b1;
                end
            end else if (tick) begin
                if (ch_idx == SEL_W'(CHANNELS - 1)) begin
                    idx_next  = '0;
                    wrap_next = 1'b1;
                end else begin
                    idx_next = ch_idx + SEL_W'(1);
                end
            end
        end
    end

    // ch_idx doubles as the channel index state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_idx    <= '0;
            ch_onehot <= '0;
            data_out  <= '0;
            wrap      <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            ch_idx    <= idx_next;
            ch_onehot <= CHANNELS'(onehot(32'(idx_next)));
            data_out  <= data_in[32'(idx_next)*WIDTH +: WIDTH];
            wrap      <= wrap_next;
            sel_err   <= sel_err_next;
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n across three parameter sets.
module tb_mux_scan_n;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [1:0]  sel;
    logic        hold;
    logic [15:0] d4;
    logic [11:0] d3;

    logic [3:0] a_dout, c_dout, b_dout;
    logic [1:0] a_idx, b_idx, c_idx;
    logic [3:0] a_oh, c_oh;
    logic [2:0] b_oh;
    logic       a_wrap, b_wrap, c_wrap;
    logic       a_err, b_err, c_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_scan_n #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) u_a (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel), .hold(hold),
        .data_in(d4), .data_out(a_dout), .ch_idx(a_idx), .ch_onehot(a_oh),
        .wrap(a_wrap), .sel_err(a_err)
    );

    mux_scan_n #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) u_b (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel), .hold(hold),
        .data_in(d3), .data_out(b_dout), .ch_idx(b_idx), .ch_onehot(b_oh),
        .wrap(b_wrap), .sel_err(b_err)
    );

    mux_scan_n #(.WIDTH(4), .CHANNELS(4), .DWELL(1)) u_c (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel), .hold(hold),
        .data_in(d4), .data_out(c_dout), .ch_idx(c_idx), .ch_onehot(c_oh),
        .wrap(c_wrap), .sel_err(c_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] d, input logic [1:0] i,
                         input logic [3:0] oh, input logic w, input logic e);
        check({tag, ".a.data"}, 32'(a_dout), 32'(d));
        check({tag, ".a.idx"},  32'(a_idx),  32'(i));
        check({tag, ".a.oh"},   32'(a_oh),   32'(oh));
        check({tag, ".a.wrap"}, 32'(a_wrap), 32'(w));
        check({tag, ".a.err"},  32'(a_err),  32'(e));
    endtask

    task automatic chk_b(input string tag, input logic [3:0] d, input logic [1:0] i,
                         input logic [2:0] oh, input logic w, input logic e);
        check({tag, ".b.data"}, 32'(b_dout), 32'(d));
        check({tag, ".b.idx"},  32'(b_idx),  32'(i));
        check({tag, ".b.oh"},   32'(b_oh),   32'(oh));
        check({tag, ".b.wrap"}, 32'(b_wrap), 32'(w));
        check({tag, ".b.err"},  32'(b_err),  32'(e));
    endtask

    task automatic chk_c(input string tag, input logic [3:0] d, input logic [1:0] i,
                         input logic [3:0] oh, input logic w, input logic e);
        check({tag, ".c.data"}, 32'(c_dout), 32'(d));
        check({tag, ".c.idx"},  32'(c_idx),  32'(i));
        check({tag, ".c.oh"},   32'(c_oh),   32'(oh));
        check({tag, ".c.wrap"}, 32'(c_wrap), 32'(w));
        check({tag, ".c.err"},  32'(c_err),  32'(e));
    endtask

    // Scan sequence for DWELL=3 after leaving manual at channel 0.
    logic [3:0] p2_d [12] = '{4'hA, 4'hA, 4'hB, 4'hB, 4'hB, 4'hC,
                              4'hC, 4'hC, 4'hD, 4'hD, 4'hD, 4'hA};
    logic [1:0] p2_i [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                              2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    logic [3:0] p6_d [8]  = '{4'hB, 4'hC, 4'hD, 4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    logic [3:0] p6_oh [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                              4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] p6_i [8]  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        reset = 1'b1; mode = 1'b0; sel = 2'd0; hold = 1'b0;
        d4 = 16'hDCBA; d3 = 12'hCBA;

        // Reset and manual select
        tick(); tick();
        chk_a("rst", 4'h0, 2'd0, 4'b0000, 1'b0, 1'b0);
        chk_b("rst", 4'h0, 2'd0, 3'b000,  1'b0, 1'b0);
        chk_c("rst", 4'h0, 2'd0, 4'b0000, 1'b0, 1'b0);
        reset = 1'b0; sel = 2'd2;
        tick(); chk_a("man2", 4'hC, 2'd2, 4'b0100, 1'b0, 1'b0);
        sel = 2'd0;
        tick(); chk_a("man0", 4'hA, 2'd0, 4'b0001, 1'b0, 1'b0);

        // Scan through all channels with wrap
        mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_a("scan", p2_d[i], p2_i[i], 4'(4'd1 << p2_i[i]), (i == 11), 1'b0);
        end

        // Hold in the middle of B's dwell, with live data update
        tick(); chk_a("h.a0", 4'hA, 2'd0, 4'b0001, 1'b0, 1'b0);
        tick(); chk_a("h.a1", 4'hA, 2'd0, 4'b0001, 1'b0, 1'b0);
        tick(); chk_a("h.b0", 4'hB, 2'd1, 4'b0010, 1'b0, 1'b0);
        tick(); chk_a("h.b1", 4'hB, 2'd1, 4'b0010, 1'b0, 1'b0);
        hold = 1'b1; sel = 2'd3;
        tick(); chk_a("h.hold1", 4'hB, 2'd1, 4'b0010, 1'b0, 1'b0);
        tick(); chk_a("h.hold2", 4'hB, 2'd1, 4'b0010, 1'b0, 1'b0);
        d4 = 16'hDC7A;
        tick(); chk_a("h.hold3", 4'h7, 2'd1, 4'b0010, 1'b0, 1'b0);
        tick(); chk_a("h.hold4", 4'h7, 2'd1, 4'b0010, 1'b0, 1'b0);
        tick(); chk_a("h.hold5", 4'h7, 2'd1, 4'b0010, 1'b0, 1'b0);
        hold = 1'b0; sel = 2'd0;
        tick(); chk_a("h.last", 4'h7, 2'd1, 4'b0010, 1'b0, 1'b0);
        d4 = 16'hDCBA;
        tick(); chk_a("h.c0", 4'hC, 2'd2, 4'b0100, 1'b0, 1'b0);

        // Mode switch mid-dwell
        tick(); chk_a("m.c1", 4'hC, 2'd2, 4'b0100, 1'b0, 1'b0);
        mode = 1'b0; sel = 2'd0;
        tick(); chk_a("m.man", 4'hA, 2'd0, 4'b0001, 1'b0, 1'b0);
        mode = 1'b1;
        tick(); chk_a("m.a1", 4'hA, 2'd0, 4'b0001, 1'b0, 1'b0);
        tick(); chk_a("m.a2", 4'hA, 2'd0, 4'b0001, 1'b0, 1'b0);
        tick(); chk_a("m.b0", 4'hB, 2'd1, 4'b0010, 1'b0, 1'b0);

        // Three channels: invalid select, reset mid-scan, odd wrap
        reset = 1'b1; mode = 1'b0;
        tick(); chk_b("b.rst", 4'h0, 2'd0, 3'b000, 1'b0, 1'b0);
        reset = 1'b0; sel = 2'd2;
        tick(); chk_b("b.sel2", 4'hC, 2'd2, 3'b100, 1'b0, 1'b0);
        sel = 2'd3;
        tick(); chk_b("b.sel3", 4'hC, 2'd2, 3'b100, 1'b0, 1'b1);
        tick(); chk_b("b.sel3b", 4'hC, 2'd2, 3'b100, 1'b0, 1'b1);
        sel = 2'd1;
        tick(); chk_b("b.sel1", 4'hB, 2'd1, 3'b010, 1'b0, 1'b0);
        mode = 1'b1;
        tick(); chk_b("b.scan", 4'hB, 2'd1, 3'b010, 1'b0, 1'b0);
        reset = 1'b1;
        tick(); chk_b("b.midrst", 4'h0, 2'd0, 3'b000, 1'b0, 1'b0);
        reset = 1'b0;
        tick(); chk_b("b.a1", 4'hA, 2'd0, 3'b001, 1'b0, 1'b0);
        tick(); chk_b("b.a2", 4'hA, 2'd0, 3'b001, 1'b0, 1'b0);
        tick(); chk_b("b.b0", 4'hB, 2'd1, 3'b010, 1'b0, 1'b0);
        tick(); chk_b("b.b1", 4'hB, 2'd1, 3'b010, 1'b0, 1'b0);
        tick(); chk_b("b.b2", 4'hB, 2'd1, 3'b010, 1'b0, 1'b0);
        tick(); chk_b("b.c0", 4'hC, 2'd2, 3'b100, 1'b0, 1'b0);
        tick(); chk_b("b.c1", 4'hC, 2'd2, 3'b100, 1'b0, 1'b0);
        tick(); chk_b("b.c2", 4'hC, 2'd2, 3'b100, 1'b0, 1'b0);
        tick(); chk_b("b.wrap", 4'hA, 2'd0, 3'b001, 1'b1, 1'b0);

        // DWELL=1: advance every cycle, hold gating
        reset = 1'b1; mode = 1'b0; sel = 2'd0;
        tick(); chk_c("c.rst", 4'h0, 2'd0, 4'b0000, 1'b0, 1'b0);
        reset = 1'b0;
        tick(); chk_c("c.man", 4'hA, 2'd0, 4'b0001, 1'b0, 1'b0);
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_c("c.scan", p6_d[i], p6_i[i], p6_oh[i], (i == 3) || (i == 7), 1'b0);
        end
        hold = 1'b1;
        tick(); chk_c("c.h1", 4'hA, 2'd0, 4'b0001, 1'b0, 1'b0);
        hold = 1'b0;
        tick(); chk_c("c.r1", 4'hB, 2'd1, 4'b0010, 1'b0, 1'b0);
        hold = 1'b1;
        tick(); chk_c("c.h2", 4'hB, 2'd1, 4'b0010, 1'b0, 1'b0);
        hold = 1'b0;
        tick(); chk_c("c.r2", 4'hC, 2'd2, 4'b0100, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
